// File: rtl/mul32_seq_ctrl.sv
// Sequential 32x32 -> 64-bit unsigned multiplier controller.
// One shift-and-add step per clock through an external shared 32-bit adder.
// The partial product lives in {hi, lo}: lo starts as the multiplier and is
// shifted out from the bottom while the sum bits are shifted in from the top.
module mul32_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] mcand,
    input  logic [31:0] mplier,
    output logic        busy,
    output logic        done,
    output logic [63:0] product,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_ci,
    input  logic [31:0] add_s,
    input  logic        add_co
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e      state_q;
    logic [31:0] mc_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [63:0] product_q;

    // 33-bit adder result shifted right by one; the carry-out becomes hi[31].
    logic [63:0] step_d;
    logic        last_step;

    assign step_d    = {add_co, add_s, lo_q[31:1]};
    assign last_step = (cnt_q == 5'd31);

    // Adder operands: only driven while iterating, held at zero otherwise.
    always_comb begin
        add_a = 32'd0;
        add_b = 32'd0;
        if (state_q == StRun) begin
            add_a = hi_q;
            add_b = lo_q[0] ? mc_q : 32'd0;
        end
    end

    assign add_ci = 1'b0;

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            mc_q      <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            cnt_q     <= 5'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= 64'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mc_q    <= mcand;
                        hi_q    <= 32'd0;
                        lo_q    <= mplier;
                        cnt_q   <= 5'd0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    hi_q  <= step_d[63:32];
                    lo_q  <= step_d[31:0];
                    cnt_q <= cnt_q + 5'd1;
                    if (last_step) begin
                        product_q <= step_d;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    // start is deliberately ignored here; IDLE lasts at least one cycle.
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Self-checking bench for mul32_seq_ctrl with a behavioural adder and model.
module tb_mul32_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_ci;
    logic [31:0] add_s;
    logic        add_co;

    always #5 clk = ~clk;

    // Stand-in for the shared ripple-carry adder.
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_ci};

    mul32_seq_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_ci  (add_ci),
        .add_s   (add_s),
        .add_co  (add_co)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: a multiply is a 32-cycle busy window followed by a
    // one-cycle done pulse, with the product computed by plain arithmetic.
    bit          m_live = 1'b0;
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [63:0] m_prod = 64'd0;
    logic [63:0] m_pend = 64'd0;
    logic [31:0] m_mc   = 32'd0;
    int          cyc    = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_live <= 1'b1;
            m_left <= 0;
            m_done <= 1'b0;
            m_prod <= 64'd0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_prod <= m_pend;
                m_done <= 1'b1;
            end
        end else if (start) begin
            m_mc   <= mcand;
            m_pend <= 64'(mcand) * 64'(mplier);
            m_left <= 32;
        end
    end

    bit b2b       = 1'b0;
    int last_done = -1;
    int b2b_dones = 0;

    // Every-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("busy", 64'(busy), 64'(m_left > 0));
            chk("done", 64'(done), 64'(m_done));
            chk("product", product, m_prod);
            chk("add_ci", 64'(add_ci), 64'd0);
            if (m_left == 0) begin
                chk("add_a_idle", 64'(add_a), 64'd0);
                chk("add_b_idle", 64'(add_b), 64'd0);
            end else if (m_mc == 32'd0) begin
                chk("add_b_zero_mcand", 64'(add_b), 64'd0);
            end else begin
                chk("add_b_select", 64'((add_b == 32'd0) || (add_b == m_mc)), 64'd1);
            end
            if (b2b && done) begin
                if (last_done >= 0) chk("done_spacing", 64'(cyc - last_done), 64'd34);
                last_done <= cyc;
                b2b_dones <= b2b_dones + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single operation with a hand-computed expected product.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        int n;
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
        n = 1;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'd33);
        chk("product_lit", product, exp);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("product_hold", product, exp);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        mcand  = 32'd0;
        mplier = 32'd0;
        tick();
        tick();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", product, 64'd0);
        reset = 1'b0;
        tick();

        run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op(32'd0, 32'h1234_5678, 64'd0);
        run_op(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
        run_op(32'd7, 32'd9, 64'd63);

        // Abort 100 x 200 in its 10th RUN cycle.
        mcand  = 32'd100;
        mplier = 32'd200;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_product", product, 64'd0);
        repeat (40) tick();
        run_op(32'd100, 32'd200, 64'd20000);

        // Reset wins over start in the same cycle.
        start = 1'b1;
        reset = 1'b1;
        mcand = 32'd5;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 64'(busy), 64'd0);
        tick();
        chk("rst_start_busy2", 64'(busy), 64'd0);

        // Start held high with operands changing every cycle.
        b2b   = 1'b1;
        start = 1'b1;
        repeat (34 * 4) begin
            mcand  = $urandom;
            mplier = $urandom;
            tick();
        end
        start = 1'b0;
        repeat (40) tick();
        b2b = 1'b0;
        chk("b2b_done_count", 64'(b2b_dones), 64'd4);

        // Random operations with noise on start and operands while running.
        repeat (20) begin
            mcand  = $urandom;
            mplier = $urandom;
            if ($urandom_range(0, 3) == 0) mcand[31] = 1'b1;
            if ($urandom_range(0, 3) == 0) mplier = mplier & 32'h0000_00FF;
            start = 1'b1;
            tick();
            repeat (33 + $urandom_range(0, 3)) begin
                start  = 1'($urandom_range(0, 1));
                mcand  = $urandom;
                mplier = $urandom;
                tick();
            end
            start = 1'b0;
            repeat (3) tick();
        end
        repeat (40) tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
